// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the control inputs and fetch/status outputs of pc_sequencer.
//   master : the control side (decode/branch unit, or a testbench).
//            Drives start_pc, stall, halt, branch_taken, branch_target,
//            jump, call, ret and jump_target.
//   slave  : the sequencer itself. Drives pc, pc_valid, halted,
//            ras_empty, ras_full, ras_overflow and ras_underflow.
// Parameter WIDTH sets the PC/target width and must match the sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] start_pc;
  logic             stall;
  logic             halt;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             halted;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output start_pc, stall, halt, branch_taken, branch_target,
           jump, call, ret, jump_target,
    input  pc, pc_valid, halted, ras_empty, ras_full,
           ras_overflow, ras_underflow
  );

  modport slave (
    input  start_pc, stall, halt, branch_taken, branch_target,
           jump, call, ret, jump_target,
    output pc, pc_valid, halted, ras_empty, ras_full,
           ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer for the fetch stage. Holds the architectural PC,
// advances it by STEP per instruction, and redirects on branch, jump,
// call and return. A circular return-address stack (RAS) backs call/ret.
//
// Ports:
//   CLK    : clock; every state update happens on the FALLING edge
//   RESET  : synchronous, active-low reset (loads bus.start_pc)
//   bus    : pc_sequencer_if.slave - controls in, pc/status out
//
// Parameters:
//   WIDTH     : PC and target width in bits
//   STEP      : byte increment per sequential instruction
//   RAS_DEPTH : return-address stack entries (power of two, >= 2)
//
// Build option:
//   PC_SEQ_RAS_EN : when defined the RAS is built. When undefined no
//                   storage exists, call acts as jump, ret is ignored,
//                   ras_empty reads 1 and the other RAS flags read 0.
//
// All outputs come straight from registers.
module pc_sequencer #(
  parameter int WIDTH     = 32,
  parameter int STEP      = 4,
  parameter int RAS_DEPTH = 4
) (
  input logic           CLK,
  input logic           RESET,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic             pc_valid_reg, pc_valid_next;
  logic             halted_reg, halted_next;

  // Sequential successor; wraps modulo 2^WIDTH with no flag.
  assign pc_inc = pc_reg + WIDTH'(STEP);

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // sp_reg points at the next slot to write; the top of stack sits one
  // below it. When the stack is full, sp_reg also points at the oldest
  // entry, so a push there overwrites it naturally.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp_reg, sp_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ras_empty_reg, ras_full_reg;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             push, pop;
  logic [WIDTH-1:0] ras_top;

  assign ras_top = ras_mem[sp_reg - PTR_W'(1)];
`else
  // ret has no meaning without the stack.
  logic unused_ret;
  assign unused_ret = bus.ret;
`endif

  // Next-state and next-PC selection.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pc_valid_next = pc_valid_reg;
    halted_next   = halted_reg;
`ifdef PC_SEQ_RAS_EN
    push     = 1'b0;
    pop      = 1'b0;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
`endif
    case (state_reg)
      ST_INIT: begin
        // First edge after reset only qualifies start_pc; controls ignored.
        if (!bus.stall) begin
          state_next    = ST_RUN;
          pc_valid_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            state_next    = ST_HALTED;
            pc_valid_next = 1'b0;
            halted_next   = 1'b1;
          end
`ifdef PC_SEQ_RAS_EN
          else if (bus.ret) begin
            // ret outranks call, so call+ret pops (or underflows) only.
            if (cnt_reg == '0) begin
              pc_next  = pc_inc;
              unf_next = 1'b1;
            end else begin
              pc_next = ras_top;
              pop     = 1'b1;
            end
          end else if (bus.call) begin
            pc_next = bus.jump_target;
            push    = 1'b1;
            if (cnt_reg == CNT_FULL) begin
              ovf_next = 1'b1;
            end
          end
`endif
          // Without the stack, call degenerates into a plain jump.
          else if (bus.jump || bus.call) begin
            pc_next = bus.jump_target;
          end else if (bus.branch_taken) begin
            pc_next = bus.branch_target;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      ST_HALTED: begin
        // Sticky until reset.
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(negedge CLK) begin
    if (!RESET) begin
      state_reg    <= ST_INIT;
      pc_reg       <= bus.start_pc;
      pc_valid_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pc_valid_reg <= pc_valid_next;
      halted_reg   <= halted_next;
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Occupancy saturates at RAS_DEPTH; pushing while full only moves sp.
  always_comb begin
    sp_next  = sp_reg;
    cnt_next = cnt_reg;
    if (push) begin
      sp_next = sp_reg + PTR_W'(1);
      if (cnt_reg != CNT_FULL) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (pop) begin
      sp_next  = sp_reg - PTR_W'(1);
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(negedge CLK) begin
    if (!RESET) begin
      sp_reg        <= '0;
      cnt_reg       <= '0;
      ras_empty_reg <= 1'b1;
      ras_full_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      cnt_reg       <= cnt_next;
      ras_empty_reg <= (cnt_next == '0);
      ras_full_reg  <= (cnt_next == CNT_FULL);
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
    end
  end

  // Storage has no reset; contents are only read when cnt_reg says valid.
  always_ff @(negedge CLK) begin
    if (RESET && push) begin
      ras_mem[sp_reg] <= pc_inc;
    end
  end

  assign bus.ras_empty     = ras_empty_reg;
  assign bus.ras_full      = ras_full_reg;
  assign bus.ras_overflow  = ovf_reg;
  assign bus.ras_underflow = unf_reg;
`else
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_full      = 1'b0;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  assign bus.pc       = pc_reg;
  assign bus.pc_valid = pc_valid_reg;
  assign bus.halted   = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed test of pc_sequencer (WIDTH=32, STEP=4, RAS_DEPTH=4).
// Expected values follow the RAS build when PC_SEQ_RAS_EN is defined and
// the stackless build otherwise. Inputs are driven 1 time unit after the
// falling edge; outputs are sampled at the same point.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic CLK;
  logic RESET;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH(32),
    .STEP(4),
    .RAS_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
    $display("t=%0t pc=%h valid=%b halted=%b empty=%b full=%b ovf=%b unf=%b",
             $time, bus.pc, bus.pc_valid, bus.halted, bus.ras_empty,
             bus.ras_full, bus.ras_overflow, bus.ras_underflow);
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.halt          = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.jump_target   = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.start_pc = 32'h100;
    RESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_cnt++; if (bus.pc !== 32'h100) $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h100); else pass_cnt++;
      check_cnt++; if (bus.pc_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.pc_valid); else pass_cnt++;
      check_cnt++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", bus.halted); else pass_cnt++;
      check_cnt++; if (bus.ras_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.ras_empty); else pass_cnt++;
      check_cnt++; if ({bus.ras_full, bus.ras_overflow, bus.ras_underflow} !== 3'b000)
        $display("FAIL reset_ras_flags: got %b want 000", {bus.ras_full, bus.ras_overflow, bus.ras_underflow}); else pass_cnt++;
    end
    RESET = 1'b1;
    tick();
    check_cnt++; if (bus.pc !== 32'h100) $display("FAIL first_fetch_pc: got %h want %h", bus.pc, 32'h100); else pass_cnt++;
    check_cnt++; if (bus.pc_valid !== 1'b1) $display("FAIL first_fetch_valid: got %b want 1", bus.pc_valid); else pass_cnt++;
    tick();
    check_cnt++; if (bus.pc !== 32'h104) $display("FAIL advance1: got %h want %h", bus.pc, 32'h104); else pass_cnt++;
    tick();
    check_cnt++; if (bus.pc !== 32'h108) $display("FAIL advance2: got %h want %h", bus.pc, 32'h108); else pass_cnt++;
  endtask

  task automatic test_redirect();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    bus.jump          = 1'b1;
    bus.jump_target   = 32'h300;
    tick();
    check_cnt++; if (bus.pc !== 32'h300) $display("FAIL jump_over_branch: got %h want %h", bus.pc, 32'h300); else pass_cnt++;
    bus.jump = 1'b0;
    tick();
    check_cnt++; if (bus.pc !== 32'h200) $display("FAIL branch_alone: got %h want %h", bus.pc, 32'h200); else pass_cnt++;
    bus.branch_taken = 1'b0;
    tick();
    check_cnt++; if (bus.pc !== 32'h204) $display("FAIL after_branch: got %h want %h", bus.pc, 32'h204); else pass_cnt++;
  endtask

  task automatic test_call_ret();
    logic [31:0] exp_pc;
    bus.jump        = 1'b1;
    bus.jump_target = 32'h40;
    tick();
    check_cnt++; if (bus.pc !== 32'h40) $display("FAIL jump_to_40: got %h want %h", bus.pc, 32'h40); else pass_cnt++;
    bus.jump        = 1'b0;
    bus.call        = 1'b1;
    bus.jump_target = 32'h800;
    tick();
    check_cnt++; if (bus.pc !== 32'h800) $display("FAIL call_pc: got %h want %h", bus.pc, 32'h800); else pass_cnt++;
    check_cnt++; if (bus.ras_empty !== !RAS_ON) $display("FAIL call_empty: got %b want %b", bus.ras_empty, !RAS_ON); else pass_cnt++;
    bus.call = 1'b0;
    tick();
    tick();
    check_cnt++; if (bus.pc !== 32'h808) $display("FAIL callee_advance: got %h want %h", bus.pc, 32'h808); else pass_cnt++;
    bus.ret = 1'b1;
    tick();
    exp_pc = RAS_ON ? 32'h44 : 32'h80C;
    check_cnt++; if (bus.pc !== exp_pc) $display("FAIL ret_pc: got %h want %h", bus.pc, exp_pc); else pass_cnt++;
    check_cnt++; if (bus.ras_empty !== 1'b1) $display("FAIL ret_empty: got %b want 1", bus.ras_empty); else pass_cnt++;
    bus.ret = 1'b0;
  endtask

  task automatic test_ras_overflow_underflow();
    logic [31:0] ret_on [5];
    logic [31:0] ret_off [5];
    logic [31:0] exp_pc;
    ret_on  = '{32'h2304, 32'h2204, 32'h2104, 32'h2004, 32'h2008};
    ret_off = '{32'h2404, 32'h2408, 32'h240C, 32'h2410, 32'h2414};
    bus.jump        = 1'b1;
    bus.jump_target = 32'h1000;
    tick();
    bus.jump = 1'b0;
    check_cnt++; if (bus.pc !== 32'h1000) $display("FAIL jump_to_1000: got %h want %h", bus.pc, 32'h1000); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      bus.call        = 1'b1;
      bus.jump_target = 32'h2000 + 32'(i) * 32'h100;
      tick();
      check_cnt++; if (bus.pc !== bus.jump_target) $display("FAIL call%0d_pc: got %h want %h", i, bus.pc, bus.jump_target); else pass_cnt++;
      check_cnt++; if (bus.ras_full !== (RAS_ON && i >= 3)) $display("FAIL call%0d_full: got %b want %b", i, bus.ras_full, RAS_ON && i >= 3); else pass_cnt++;
      check_cnt++; if (bus.ras_overflow !== (RAS_ON && i == 4)) $display("FAIL call%0d_ovf: got %b want %b", i, bus.ras_overflow, RAS_ON && i == 4); else pass_cnt++;
    end
    bus.call = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ret = 1'b1;
      tick();
      exp_pc = RAS_ON ? ret_on[i] : ret_off[i];
      check_cnt++; if (bus.pc !== exp_pc) $display("FAIL ret%0d_pc: got %h want %h", i, bus.pc, exp_pc); else pass_cnt++;
      check_cnt++; if (bus.ras_empty !== (!RAS_ON || i >= 3)) $display("FAIL ret%0d_empty: got %b want %b", i, bus.ras_empty, !RAS_ON || i >= 3); else pass_cnt++;
      check_cnt++; if (bus.ras_underflow !== (RAS_ON && i == 4)) $display("FAIL ret%0d_unf: got %b want %b", i, bus.ras_underflow, RAS_ON && i == 4); else pass_cnt++;
    end
    // call together with ret: ret takes precedence, no push.
    bus.call        = 1'b1;
    bus.ret         = 1'b1;
    bus.jump_target = 32'h3000;
    tick();
    exp_pc = RAS_ON ? 32'h200C : 32'h3000;
    check_cnt++; if (bus.pc !== exp_pc) $display("FAIL call_ret_pc: got %h want %h", bus.pc, exp_pc); else pass_cnt++;
    check_cnt++; if (bus.ras_empty !== 1'b1) $display("FAIL call_ret_empty: got %b want 1", bus.ras_empty); else pass_cnt++;
    check_cnt++; if (bus.ras_overflow !== RAS_ON) $display("FAIL ovf_sticky: got %b want %b", bus.ras_overflow, RAS_ON); else pass_cnt++;
    idle();
  endtask

  task automatic test_stall_halt();
    bus.jump        = 1'b1;
    bus.jump_target = 32'h10;
    tick();
    check_cnt++; if (bus.pc !== 32'h10) $display("FAIL jump_to_10: got %h want %h", bus.pc, 32'h10); else pass_cnt++;
    bus.jump_target = 32'h500;
    bus.stall       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++; if (bus.pc !== 32'h10) $display("FAIL stall%0d_pc: got %h want %h", i, bus.pc, 32'h10); else pass_cnt++;
      check_cnt++; if (bus.pc_valid !== 1'b1) $display("FAIL stall%0d_valid: got %b want 1", i, bus.pc_valid); else pass_cnt++;
    end
    bus.stall = 1'b0;
    bus.jump  = 1'b0;
    bus.halt  = 1'b1;
    tick();
    check_cnt++; if (bus.halted !== 1'b1) $display("FAIL halt_flag: got %b want 1", bus.halted); else pass_cnt++;
    check_cnt++; if (bus.pc_valid !== 1'b0) $display("FAIL halt_valid: got %b want 0", bus.pc_valid); else pass_cnt++;
    check_cnt++; if (bus.pc !== 32'h10) $display("FAIL halt_pc: got %h want %h", bus.pc, 32'h10); else pass_cnt++;
    bus.halt = 1'b0;
    bus.jump = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_cnt++; if (bus.pc !== 32'h10) $display("FAIL halted%0d_pc: got %h want %h", i, bus.pc, 32'h10); else pass_cnt++;
      check_cnt++; if (bus.halted !== 1'b1) $display("FAIL halted%0d_flag: got %b want 1", i, bus.halted); else pass_cnt++;
    end
    // Reset wins over stall and halt.
    bus.jump     = 1'b0;
    bus.stall    = 1'b1;
    bus.halt     = 1'b1;
    bus.start_pc = 32'h100;
    RESET        = 1'b0;
    tick();
    check_cnt++; if (bus.pc !== 32'h100) $display("FAIL rereset_pc: got %h want %h", bus.pc, 32'h100); else pass_cnt++;
    check_cnt++; if ({bus.pc_valid, bus.halted} !== 2'b00) $display("FAIL rereset_valid_halted: got %b want 00", {bus.pc_valid, bus.halted}); else pass_cnt++;
    check_cnt++; if ({bus.ras_overflow, bus.ras_underflow} !== 2'b00)
      $display("FAIL rereset_sticky: got %b want 00", {bus.ras_overflow, bus.ras_underflow}); else pass_cnt++;
    RESET    = 1'b1;
    bus.halt = 1'b0;
    tick();
    check_cnt++; if (bus.pc_valid !== 1'b0) $display("FAIL init_stall_valid: got %b want 0", bus.pc_valid); else pass_cnt++;
    // Controls are ignored on the INIT -> RUN edge, halt included.
    bus.stall = 1'b0;
    bus.halt  = 1'b1;
    tick();
    check_cnt++; if ({bus.pc_valid, bus.halted} !== 2'b10) $display("FAIL init_release: got %b want 10", {bus.pc_valid, bus.halted}); else pass_cnt++;
    check_cnt++; if (bus.pc !== 32'h100) $display("FAIL init_release_pc: got %h want %h", bus.pc, 32'h100); else pass_cnt++;
    bus.halt = 1'b0;
    tick();
    check_cnt++; if (bus.pc !== 32'h104) $display("FAIL post_init_advance: got %h want %h", bus.pc, 32'h104); else pass_cnt++;
  endtask

  task automatic test_wrap();
    idle();
    bus.start_pc = 32'hFFFF_FFFC;
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    check_cnt++; if (bus.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_start: got %h want %h", bus.pc, 32'hFFFF_FFFC); else pass_cnt++;
    tick();
    check_cnt++; if (bus.pc !== 32'h0) $display("FAIL wrap_zero: got %h want %h", bus.pc, 32'h0); else pass_cnt++;
    tick();
    check_cnt++; if (bus.pc !== 32'h4) $display("FAIL wrap_next: got %h want %h", bus.pc, 32'h4); else pass_cnt++;
  endtask

  initial begin
    RESET = 1'b0;
    bus.start_pc = '0;
    idle();
    test_reset();
    test_redirect();
    test_call_ret();
    test_ras_overflow_underflow();
    test_stall_halt();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
